spi_byte_arbiter: RTL and testbench
===================================

Name: spi_byte_arbiter

Overview:
- Shares one SPI byte engine between two requesters, client 0 and client 1, using round-robin arbitration.
- The engine accepts a parallel byte write pulse, accepts a read request level, returns the read byte, and drives chip select.
- Sits between the engine and the host-command and stream FSMs in the top level, and sequences each single-byte transaction through the engine's handshake.
- Adds a per-transaction watchdog so a stalled engine cannot hang either client.

Parameters:
- TMO_W, 10, width of the watchdog counter.
- TMO_CYCLES, 1000, CLK cycles allowed per transaction before abort; must be below 2^TMO_W.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  async active-low reset
- REQ0, REQ1  in  1  client request level; held until ACKn
- RNW0, RNW1  in  1  1 = read byte, 0 = write byte; stable while REQn is high
- WDATA0, WDATA1  in  8  write byte; stable while REQn is high
- ACK0, ACK1  out  1  one-cycle completion pulse
- ERR0, ERR1  out  1  one-cycle pulse, coincident with ACKn, on timeout
- RDATA  out  8  read byte; valid on ACKn of a read
- IF_DIN  out  8  byte to engine
- IF_WE_IN  out  1  one-cycle write strobe to engine
- IF_RDY_OUT  out  1  read request level to engine
- IF_DOUT  in  8  engine read byte
- IF_WE_OUT_N  in  1  engine read-complete flag; high = byte valid
- IF_CS_N  in  1  engine chip select; low = engine busy
- OWNER  out  1  client currently granted, for debug

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer = 0, watchdog = 0.
- Arbitration (in IDLE only):
  - Only one request pending: grant that client.
  - Both pending: grant the client not served last; pointer starts at 0, so client 0 wins the first tie.
  - Pointer updates when a grant is issued.
  - Grant latches RNW, WDATA and owner into local registers; later changes on the client inputs are ignored.
- States:
  - IDLE: any REQ -> WR_ISSUE if latched RNW = 0, else RD_REQ. Requires IF_CS_N = 1 and IF_WE_OUT_N = 0; otherwise stay in IDLE.
  - WR_ISSUE: IF_DIN = latched byte, IF_WE_IN = 1 for exactly this cycle -> WR_START.
  - WR_START: wait for IF_CS_N = 0 -> WR_BUSY.
  - WR_BUSY: wait for IF_CS_N = 1 -> DONE.
  - RD_REQ: IF_RDY_OUT = 1 (held through RD_WAIT); wait for IF_WE_OUT_N = 1 -> RD_WAIT.
  - RD_WAIT: register RDATA <= IF_DOUT; IF_RDY_OUT = 0 next cycle -> RD_REL.
  - RD_REL: wait for IF_WE_OUT_N = 0 and IF_CS_N = 1 (engine back in idle) -> DONE.
  - DONE: ACKn = 1 for 1 cycle -> IDLE.
- IF_DIN holds the last written byte outside WR_ISSUE.
- Latency from grant to ACK = engine time + 3 CLK minimum.
- Clients must see ACK and drop REQ within 1 cycle to avoid being re-granted. A REQ still high in IDLE is a new request.
- Watchdog:
  - Clears on grant; counts in every non-IDLE, non-DONE state.
  - At TMO_CYCLES: go to ABORT.
- ABORT:
  - Deassert IF_RDY_OUT and drive IF_WE_IN = 0.
  - Wait for IF_CS_N = 1 and IF_WE_OUT_N = 0, bounded by a second TMO_CYCLES period after which the wait is forced complete.
  - Then DONE with ERRn = 1 alongside ACKn. RDATA is unchanged on abort.
- Simultaneous REQ rise and ACK of the other client: the new request is considered in the next IDLE cycle only.
- Reset mid-transaction: immediate return to reset values; no ACK is produced; the engine is reset by the same RST_N.
- RDATA is shared and is valid only in the ACK cycle of a read. Owner is given by which ACKn fires.

Decomposition:
- Shared package/include: state encodings (one-hot, 9 states), the TMO_CYCLES default, and client index constants.
- Sub-module: spi_rr_arbiter (2-way round-robin grant, pointer register, grant-enable input). Sequencer FSM and watchdog stay in the top module.

Test Plan:
- REQ0 = 1, RNW0 = 0, WDATA0 = 8'hA5 against the engine model: one IF_WE_IN pulse with IF_DIN = 8'hA5. Then ACK0 after IF_CS_N returns high; ERR0 = 0.
- REQ1 read with the engine returning 8'h3C: IF_RDY_OUT is held until IF_WE_OUT_N = 1, and RDATA = 8'h3C on the ACK1 cycle. IF_RDY_OUT is low before ACK1.
- REQ0 and REQ1 both held for 4 transactions: grants alternate 0, 1, 0, 1, and OWNER matches each grant.
- Engine stub that never raises IF_WE_OUT_N, with TMO_CYCLES = 16: ACK1 and ERR1 fire 16 cycles after grant plus the abort wait, and IF_RDY_OUT = 0. The next request is served normally.
- RST_N asserted during WR_BUSY: all outputs 0 asynchronously, no ACK. After release, a write with REQ0 = 1, RNW0 = 0, WDATA0 = 8'h5A completes with ACK0 and ERR0 = 0.
- WDATA0 changed from 8'h11 to 8'h22 one cycle after grant: IF_DIN = 8'h11 on IF_WE_IN.

Source files
------------

// File: rtl/spi_byte_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_byte_arbiter_pkg
// Brief    : Shared state encodings, defaults and types for spi_byte_arbiter
// Revision : 1.0 - initial release
// ============================================================================
package spi_byte_arbiter_pkg;

  localparam int TMO_W_DEF      = 10;
  localparam int TMO_CYCLES_DEF = 1000;

  localparam logic CLIENT0 = 1'b0;
  localparam logic CLIENT1 = 1'b1;

  // One-hot sequencer states
  localparam logic [8:0] ST_IDLE     = 9'b0_0000_0001;
  localparam logic [8:0] ST_WR_ISSUE = 9'b0_0000_0010;
  localparam logic [8:0] ST_WR_START = 9'b0_0000_0100;
  localparam logic [8:0] ST_WR_BUSY  = 9'b0_0000_1000;
  localparam logic [8:0] ST_RD_REQ   = 9'b0_0001_0000;
  localparam logic [8:0] ST_RD_WAIT  = 9'b0_0010_0000;
  localparam logic [8:0] ST_RD_REL   = 9'b0_0100_0000;
  localparam logic [8:0] ST_DONE     = 9'b0_1000_0000;
  localparam logic [8:0] ST_ABORT    = 9'b1_0000_0000;

  // States in which the watchdog is counting toward an abort
  localparam logic [8:0] ST_ACTIVE_MASK = ST_WR_ISSUE | ST_WR_START | ST_WR_BUSY |
                                          ST_RD_REQ | ST_RD_WAIT | ST_RD_REL;

  // Transaction captured at grant time
  typedef struct packed {
    logic       owner;
    logic       rnw;
    logic [7:0] wdata;
  } txn_t;

endpackage
`default_nettype wire

// File: rtl/spi_byte_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_byte_arbiter_if
// Brief    : Client and byte-engine signal bundle for spi_byte_arbiter
// Revision : 1.0 - initial release
// ============================================================================
interface spi_byte_arbiter_if;

  // Client side
  logic       REQ0;
  logic       REQ1;
  logic       RNW0;
  logic       RNW1;
  logic [7:0] WDATA0;
  logic [7:0] WDATA1;
  logic       ACK0;
  logic       ACK1;
  logic       ERR0;
  logic       ERR1;
  logic [7:0] RDATA;
  logic       OWNER;

  // Byte engine side
  logic [7:0] IF_DIN;
  logic       IF_WE_IN;
  logic       IF_RDY_OUT;
  logic [7:0] IF_DOUT;
  logic       IF_WE_OUT_N;
  logic       IF_CS_N;

  // Arbiter view
  modport slave (
    input  REQ0, REQ1, RNW0, RNW1, WDATA0, WDATA1,
    output ACK0, ACK1, ERR0, ERR1, RDATA, OWNER,
    output IF_DIN, IF_WE_IN, IF_RDY_OUT,
    input  IF_DOUT, IF_WE_OUT_N, IF_CS_N
  );

  // Clients plus engine view
  modport master (
    output REQ0, REQ1, RNW0, RNW1, WDATA0, WDATA1,
    input  ACK0, ACK1, ERR0, ERR1, RDATA, OWNER,
    input  IF_DIN, IF_WE_IN, IF_RDY_OUT,
    output IF_DOUT, IF_WE_OUT_N, IF_CS_N
  );

endinterface
`default_nettype wire

// File: rtl/spi_byte_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : spi_rr_arbiter
// Brief    : Two-way round-robin grant with pointer to the preferred client
// Revision : 1.0 - initial release
// ============================================================================
module spi_rr_arbiter
  import spi_byte_arbiter_pkg::*;
(
  input  wire logic       CLK,
  input  wire logic       RST_N,
  input  wire logic [1:0] req,
  input  wire logic       grant_en,
  output logic            gnt_valid,
  output logic            gnt_idx
);

  // ptr_q names the client that wins the next tie
  logic ptr_q;
  logic ptr_d;

  // Pick a client; on a tie the pointer decides, then moves past the winner
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = req[1] & (~req[0] | ptr_q);
    ptr_d     = ptr_q;
    if (grant_en && gnt_valid) begin
      ptr_d = (gnt_idx == CLIENT1) ? CLIENT0 : CLIENT1;
    end
  end

  // Pointer register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_q <= CLIENT0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_byte_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_byte_arbiter
// Brief    : Shares one SPI byte engine between two clients, round-robin,
//            with a per-transaction watchdog
// Revision : 1.0 - initial release
// ============================================================================
module spi_byte_arbiter
  import spi_byte_arbiter_pkg::*;
#(
  parameter int TMO_W      = TMO_W_DEF,
  parameter int TMO_CYCLES = TMO_CYCLES_DEF
) (
  input wire logic          CLK,
  input wire logic          RST_N,
  spi_byte_arbiter_if.slave bus
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

  logic [8:0]       state_q, state_d;
  txn_t             txn_q, txn_d;
  logic [7:0]       din_q, din_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [TMO_W-1:0] wdt_q, wdt_d;

  logic engine_idle;
  logic grant_en;
  logic gnt_valid;
  logic gnt_idx;
  logic wdt_hit;

  assign engine_idle = bus.IF_CS_N && !bus.IF_WE_OUT_N;
  assign grant_en    = (state_q == ST_IDLE) && engine_idle;
  assign wdt_hit     = (wdt_q == TMO_LAST);

  spi_rr_arbiter u_arb (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .req       ({bus.REQ1, bus.REQ0}),
    .grant_en  (grant_en),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Sequencer: steps one byte through the engine handshake, aborts on watchdog
  always_comb begin
    state_d = state_q;
    txn_d   = txn_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    wdt_d   = wdt_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_en && gnt_valid) begin
          txn_d.owner = gnt_idx;
          txn_d.rnw   = (gnt_idx == CLIENT1) ? bus.RNW1   : bus.RNW0;
          txn_d.wdata = (gnt_idx == CLIENT1) ? bus.WDATA1 : bus.WDATA0;
          wdt_d       = '0;
          err_d       = 1'b0;
          if (txn_d.rnw) begin
            state_d = ST_RD_REQ;
          end else begin
            din_d   = txn_d.wdata;
            state_d = ST_WR_ISSUE;
          end
        end
      end
      ST_WR_ISSUE: state_d = ST_WR_START;
      ST_WR_START: if (!bus.IF_CS_N) state_d = ST_WR_BUSY;
      ST_WR_BUSY:  if (bus.IF_CS_N)  state_d = ST_DONE;
      ST_RD_REQ:   if (bus.IF_WE_OUT_N) state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        // A timeout landing here must leave the previous read byte intact
        if (!wdt_hit) rdata_d = bus.IF_DOUT;
        state_d = ST_RD_REL;
      end
      ST_RD_REL:   if (engine_idle) state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      ST_ABORT: begin
        // Second watchdog period bounds the wait for the engine to settle
        if (engine_idle || wdt_hit) begin
          state_d = ST_DONE;
        end else begin
          wdt_d = wdt_q + 1'b1;
        end
      end
      default:     state_d = ST_IDLE;
    endcase

    if ((state_q & ST_ACTIVE_MASK) != '0) begin
      if (wdt_hit) begin
        state_d = ST_ABORT;
        wdt_d   = '0;
        err_d   = 1'b1;
      end else begin
        wdt_d = wdt_q + 1'b1;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      txn_q   <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      wdt_q   <= '0;
    end else begin
      state_q <= state_d;
      txn_q   <= txn_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      wdt_q   <= wdt_d;
    end
  end

  assign bus.ACK0       = (state_q == ST_DONE) && (txn_q.owner == CLIENT0);
  assign bus.ACK1       = (state_q == ST_DONE) && (txn_q.owner == CLIENT1);
  assign bus.ERR0       = bus.ACK0 && err_q;
  assign bus.ERR1       = bus.ACK1 && err_q;
  assign bus.RDATA      = rdata_q;
  assign bus.OWNER      = txn_q.owner;
  assign bus.IF_DIN     = din_q;
  assign bus.IF_WE_IN   = (state_q == ST_WR_ISSUE);
  assign bus.IF_RDY_OUT = (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_spi_byte_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_byte_arbiter
// Brief    : Scoreboard bench for spi_byte_arbiter with a byte-engine model
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_byte_arbiter;

  localparam int TMO = 16;

  logic CLK;
  logic RST_N;

  spi_byte_arbiter_if bus ();

  spi_byte_arbiter #(
    .TMO_W      (10),
    .TMO_CYCLES (TMO)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- byte engine model ----------------
  logic [7:0] rd_byte;
  logic       stall;
  logic [1:0] eng_st;
  int         eng_cnt;

  // Write: CS_N low for a few cycles after the strobe.
  // Read: CS_N low, then WE_OUT_N high with data until RDY_OUT drops.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bus.IF_CS_N     <= 1'b1;
      bus.IF_WE_OUT_N <= 1'b0;
      bus.IF_DOUT     <= 8'h00;
      eng_st          <= 2'd0;
      eng_cnt         <= 0;
    end else begin
      case (eng_st)
        2'd0: begin
          if (bus.IF_WE_IN) begin
            eng_st  <= 2'd1;
            eng_cnt <= 3;
          end else if (bus.IF_RDY_OUT && !stall) begin
            eng_st      <= 2'd2;
            bus.IF_CS_N <= 1'b0;
            eng_cnt     <= 3;
          end
        end
        2'd1: begin
          if (eng_cnt == 0) begin
            bus.IF_CS_N <= 1'b1;
            eng_st      <= 2'd0;
          end else begin
            bus.IF_CS_N <= 1'b0;
            eng_cnt     <= eng_cnt - 1;
          end
        end
        2'd2: begin
          if (eng_cnt == 0) begin
            bus.IF_CS_N     <= 1'b1;
            bus.IF_WE_OUT_N <= 1'b1;
            bus.IF_DOUT     <= rd_byte;
            eng_st          <= 2'd3;
          end else begin
            eng_cnt <= eng_cnt - 1;
          end
        end
        default: begin
          if (!bus.IF_RDY_OUT) begin
            bus.IF_WE_OUT_N <= 1'b0;
            eng_st          <= 2'd0;
          end
        end
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic       client;
    logic       err;
    logic       is_rd;
    logic [7:0] rdata;
  } exp_t;

  exp_t       ack_q[$];
  logic [7:0] wr_q[$];
  int         n_cmp;
  int         n_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic we_prev;
    exp_t x;
    logic [7:0] w;
    we_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST_N) begin
        if (bus.IF_WE_IN) begin
          if (wr_q.size() == 0) begin
            chk("unexpected_write_strobe", 1, 0);
          end else begin
            w = wr_q.pop_front();
            chk("if_din_on_strobe", {24'd0, bus.IF_DIN}, {24'd0, w});
          end
        end
        if (bus.ACK0 || bus.ACK1) begin
          if (ack_q.size() == 0) begin
            chk("unexpected_ack", {30'd0, bus.ACK1, bus.ACK0}, 0);
          end else begin
            x = ack_q.pop_front();
            chk("ack_client", {30'd0, bus.ACK1, bus.ACK0}, x.client ? 32'd2 : 32'd1);
            chk("owner", {31'd0, bus.OWNER}, {31'd0, x.client});
            chk("err", {30'd0, bus.ERR1, bus.ERR0},
                x.err ? (x.client ? 32'd2 : 32'd1) : 32'd0);
            chk("rdy_low_at_ack", {31'd0, bus.IF_RDY_OUT}, 0);
            if (x.is_rd) chk("rdata", {24'd0, bus.RDATA}, {24'd0, x.rdata});
          end
        end
        if (bus.IF_WE_OUT_N && !we_prev) chk("rdy_held_to_we_out", {31'd0, bus.IF_RDY_OUT}, 1);
        we_prev = bus.IF_WE_OUT_N;
      end else begin
        we_prev = 1'b0;
      end
    end
  endtask

  // Queue expectations then run one client transaction up to its ACK
  task automatic do_txn(input logic cl, input logic rnw, input logic [7:0] wd,
                        input logic [7:0] rb, input logic exp_err,
                        input logic [7:0] exp_rd, input bit push,
                        input bit chg, input bit chk_lat);
    exp_t e;
    int   k;
    bit   got;
    if (push) begin
      e.client = cl; e.err = exp_err; e.is_rd = rnw; e.rdata = exp_rd;
      ack_q.push_back(e);
      if (!rnw) wr_q.push_back(wd);
    end
    if (rnw) rd_byte = rb;
    @(negedge CLK);
    if (cl) begin bus.REQ1 = 1'b1; bus.RNW1 = rnw; bus.WDATA1 = wd; end
    else    begin bus.REQ0 = 1'b1; bus.RNW0 = rnw; bus.WDATA0 = wd; end
    k = 0; got = 1'b0;
    while (!got && k < 300) begin
      @(negedge CLK);
      k++;
      if (chg && k == 1) begin
        if (cl) bus.WDATA1 = 8'h22; else bus.WDATA0 = 8'h22;
      end
      if (cl ? bus.ACK1 : bus.ACK0) got = 1'b1;
    end
    if (cl) bus.REQ1 = 1'b0; else bus.REQ0 = 1'b0;
    if (!got) chk("ack_timeout", 0, 1);
    if (chk_lat) chk("abort_latency", k, TMO + 2);
  endtask

  function automatic logic [31:0] out_vec();
    return {10'd0, bus.ACK0, bus.ACK1, bus.ERR0, bus.ERR1, bus.RDATA,
            bus.IF_DIN, bus.IF_WE_IN, bus.IF_RDY_OUT, bus.OWNER};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int k;
    n_cmp = 0; n_bad = 0;
    rd_byte = 8'h00; stall = 1'b0;
    bus.REQ0 = 0; bus.REQ1 = 0; bus.RNW0 = 0; bus.RNW1 = 0;
    bus.WDATA0 = 0; bus.WDATA1 = 0;
    RST_N = 1'b0;
    fork monitor(); join_none

    repeat (3) @(negedge CLK);
    chk("reset_outputs", out_vec(), 0);
    RST_N = 1'b1;

    // Plain write from client 0
    do_txn(1'b0, 1'b0, 8'hA5, 8'h00, 1'b0, 8'h00, 1, 0, 0);
    // Read from client 1
    do_txn(1'b1, 1'b1, 8'h00, 8'h3C, 1'b0, 8'h3C, 1, 0, 0);

    // Both clients hold requests: grants alternate 0,1,0,1
    ack_q.push_back('{1'b0, 1'b0, 1'b0, 8'h00}); wr_q.push_back(8'h01);
    ack_q.push_back('{1'b1, 1'b0, 1'b0, 8'h00}); wr_q.push_back(8'h02);
    ack_q.push_back('{1'b0, 1'b0, 1'b0, 8'h00}); wr_q.push_back(8'h03);
    ack_q.push_back('{1'b1, 1'b0, 1'b0, 8'h00}); wr_q.push_back(8'h04);
    fork
      begin
        do_txn(1'b0, 1'b0, 8'h01, 8'h00, 1'b0, 8'h00, 0, 0, 0);
        do_txn(1'b0, 1'b0, 8'h03, 8'h00, 1'b0, 8'h00, 0, 0, 0);
      end
      begin
        do_txn(1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 8'h00, 0, 0, 0);
        do_txn(1'b1, 1'b0, 8'h04, 8'h00, 1'b0, 8'h00, 0, 0, 0);
      end
    join

    // Client data changes after grant: the latched byte is written
    do_txn(1'b0, 1'b0, 8'h11, 8'h00, 1'b0, 8'h00, 1, 1, 0);

    // Stalled engine: abort, ERR with ACK, RDATA keeps the last read byte
    stall = 1'b1;
    do_txn(1'b1, 1'b1, 8'h00, 8'hEE, 1'b1, 8'h3C, 1, 0, 1);
    stall = 1'b0;
    do_txn(1'b0, 1'b1, 8'h00, 8'h77, 1'b0, 8'h77, 1, 0, 0);

    // Reset during WR_BUSY
    wr_q.push_back(8'h99);
    @(negedge CLK);
    bus.REQ1 = 1'b1; bus.RNW1 = 1'b0; bus.WDATA1 = 8'h99;
    k = 0;
    while (bus.IF_CS_N !== 1'b0 && k < 100) begin
      @(negedge CLK);
      k++;
    end
    chk("engine_busy_reached", {31'd0, bus.IF_CS_N}, 0);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1 chk("reset_mid_txn_outputs", out_vec(), 0);
    bus.REQ1 = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    do_txn(1'b0, 1'b0, 8'h5A, 8'h00, 1'b0, 8'h00, 1, 0, 0);

    repeat (5) @(negedge CLK);
    chk("scoreboard_drained", ack_q.size() + wr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
